// File: rtl/cmp_serial.sv
// cmp_serial: bit-serial five-flag comparator (eq/sg/ug/mg/xg).
// Operands arrive LSB first, one bit pair per accepted cycle. After LEN bits
// the flags are held on a valid/ready result port until consumed.
// Optional feature: define CMP_SERIAL_CLR_EN to add a synchronous 'clr' abort.
module cmp_serial #(
  parameter int LEN = 16
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CMP_SERIAL_CLR_EN
  input  logic clr,
`endif
  input  logic in_valid,
  output logic in_ready,
  input  logic a_bit,
  input  logic b_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic eq,
  output logic sg,
  output logic ug,
  output logic mg,
  output logic xg
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic            eq_acc;
  logic            gt_acc;
  logic            clr_i;
  logic            xfer;
  logic            last_bit;
  logic            d;
  logic            gt_fin;

`ifdef CMP_SERIAL_CLR_EN
  assign clr_i = clr;
`else
  assign clr_i = 1'b0;
`endif

  // A bit is taken only while accumulating; in_ready depends on state alone.
  assign xfer     = in_valid & (state == ACC);
  assign last_bit = (cnt == LAST);

  // Unsigned "A greater" decision once the MSB is folded in: a differing
  // higher bit overrides everything below it.
  assign d      = a_bit ^ b_bit;
  assign gt_fin = d ? a_bit : gt_acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; clr wins over any transfer or handshake.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && last_bit) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ACC;
        end
      end
      default: state_next = ACC;
    endcase
    if (clr_i) begin
      state_next = ACC;
    end
  end

  // Bit accumulation and result flag capture on the MSB transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      eq_acc <= 1'b1;
      gt_acc <= 1'b0;
      eq     <= 1'b0;
      sg     <= 1'b0;
      ug     <= 1'b0;
      mg     <= 1'b0;
      xg     <= 1'b0;
    end else if (clr_i) begin
      cnt    <= '0;
      eq_acc <= 1'b1;
      gt_acc <= 1'b0;
    end else if (xfer) begin
      if (last_bit) begin
        ug     <= gt_fin;
        sg     <= d ? b_bit : gt_acc;
        mg     <= ~a_bit & gt_fin;
        xg     <= b_bit | gt_fin;
        eq     <= eq_acc & ~d;
        cnt    <= '0;
        eq_acc <= 1'b1;
        gt_acc <= 1'b0;
      end else begin
        eq_acc <= eq_acc & ~d;
        gt_acc <= gt_fin;
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule
